// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the framed serial transmitter.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Counter width for a 0..cycles-1 timer; a single-cycle bit still needs one flop.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while enabled and flags the last cycle.
module bit_timer
  import serial_frame_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int TW = timer_width(BIT_CYCLES);
  localparam logic [TW-1:0] TC_VAL = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] cnt;

  // With BIT_CYCLES=1 the count never leaves 0, so tc simply follows en.
  assign tc = en && (cnt == TC_VAL);

  // Count within the current bit and wrap at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == TC_VAL) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, STOP_BITS stop bits.
//
//   state | meaning
//   IDLE  | line high, ready for a word
//   START | driving the start bit (0)
//   DATA  | driving data bits, LSB first
//   STOP  | driving the stop bit(s) (1)
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [IW-1:0]    bit_idx;
  logic             stop_cnt;
  logic             tc;
  logic             accept;

  assign ready     = (state == IDLE) && !pr;
  assign accept    = valid && ready;
  assign shreg_nxt = shreg >> 1;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk(clk),
    .rst(rst),
    .clr(pr || accept),
    .en (state != IDLE),
    .tc (tc)
  );

  // Frame sequencer; tx, busy and done are all registered here so the line is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= IDLE_LEVEL;
      busy     <= 1'b0;
      done     <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else if (pr) begin
      state    <= IDLE;
      tx       <= IDLE_LEVEL;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= IDLE_LEVEL;
          if (accept) begin
            shreg    <= data_in;
            state    <= START;
            tx       <= START_LEVEL;
            busy     <= 1'b1;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
          end
        end
        START: begin
          if (tc) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (tc) begin
            shreg <= shreg_nxt;
            if (bit_idx == LAST_IDX) begin
              state   <= STOP;
              tx      <= STOP_LEVEL;
              bit_idx <= '0;
            end else begin
              tx      <= shreg_nxt[0];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (tc) begin
            if (stop_cnt == STOP_LAST) begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              stop_cnt <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: default 8N1/4-cycle instance against a
// frame-level reference model, plus a WIDTH=1/BIT_CYCLES=1/STOP_BITS=2 corner instance.
module tb_serial_frame_tx;

  localparam int W     = 8;
  localparam int BC    = 4;
  localparam int SB    = 1;
  localparam int FRAME = (1 + W + SB) * BC;

  logic       clk = 1'b0;
  logic       rst;
  logic       pr;
  logic       valid;
  logic [7:0] data_in;
  logic       tx, busy, done, ready;

  logic       c_pr;
  logic       c_valid;
  logic [0:0] c_data;
  logic       c_tx, c_busy, c_done, c_ready;

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(W), .BIT_CYCLES(BC), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst), .pr(pr), .data_in(data_in), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy), .done(done)
  );

  serial_frame_tx #(.WIDTH(1), .BIT_CYCLES(1), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .pr(c_pr), .data_in(c_data), .valid(c_valid),
    .ready(c_ready), .tx(c_tx), .busy(c_busy), .done(c_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a frame in flight is just "word + cycles since acceptance".
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_k = 0;
  logic [7:0] m_word = '0;
  int         acc_count = 0;

  logic s_tx, s_busy, s_done, s_ready;
  logic s_ctx, s_cbusy, s_cdone, s_cready;

  typedef struct {
    logic [7:0] word;
    logic [9:0] exp_bits;   // line bits in transmit order, bit 0 first
  } vec_t;

  vec_t vec[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int idx;
    if (!m_busy) return 1'b1;
    idx = m_k / BC;
    if (idx == 0) return 1'b0;
    if (idx <= W) return m_word[idx-1];
    return 1'b1;
  endfunction

  // One clock: sample and compare mid-cycle, then advance the model across the edge.
  task automatic tick();
    logic acc;
    @(negedge clk);
    s_tx = tx; s_busy = busy; s_done = done; s_ready = ready;
    s_ctx = c_tx; s_cbusy = c_busy; s_cdone = c_done; s_cready = c_ready;
    check("tx", s_tx, exp_tx());
    check("busy", s_busy, m_busy);
    check("done", s_done, m_done);
    check("ready", s_ready, !m_busy && !pr);
    acc = valid && !m_busy && !pr;
    @(posedge clk);
    if (pr) begin
      m_busy = 1'b0; m_done = 1'b0; m_k = 0;
    end else if (acc) begin
      m_busy = 1'b1; m_done = 1'b0; m_k = 0; m_word = data_in; acc_count++;
    end else if (m_busy) begin
      m_k++;
      m_done = 1'b0;
      if (m_k == FRAME) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] word, output logic [9:0] got, output int done_at);
    valid = 1'b1; data_in = word;
    tick();
    valid = 1'b0; data_in = ~word;
    got = '0; done_at = -1;
    for (int c = 0; c <= FRAME; c++) begin
      tick();
      if (c % BC == 1) got[c / BC] = s_tx;
      if (s_done && done_at < 0) done_at = c;
    end
  endtask

  initial begin
    logic [9:0] got;
    int         done_at;
    int         dn, t0, t1, start_acc;
    logic [3:0] cgot;
    logic [3:0] cdone;
    logic [3:0] cbusy;

    vec[0] = '{8'hA5, 10'b1_1010_0101_0};
    vec[1] = '{8'h3C, 10'b1_0011_1100_0};
    vec[2] = '{8'hFF, 10'b1_1111_1111_0};
    vec[3] = '{8'h00, 10'b1_0000_0000_0};

    rst = 1'b1; pr = 1'b0; valid = 1'b0; data_in = '0;
    c_pr = 1'b0; c_valid = 1'b0; c_data = '0;

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ctx", c_tx, 1'b1);
    rst = 1'b0;

    // Idle line.
    repeat (20) tick();

    // Single frames from the table.
    for (int i = 0; i < 4; i++) begin
      send_frame(vec[i].word, got, done_at);
      check($sformatf("frame_bits_%0h", vec[i].word), got, vec[i].exp_bits);
      check($sformatf("done_latency_%0h", vec[i].word), done_at, FRAME);
    end

    // Back-to-back with valid held: second word taken on the edge closing the done cycle.
    valid = 1'b1; data_in = 8'h3C; start_acc = acc_count; dn = 0; t0 = -1; t1 = -1;
    for (int t = 0; t < 150 && dn < 2; t++) begin
      tick();
      if (s_done) begin
        if (dn == 0) t0 = t; else t1 = t;
        dn++;
      end
      if (acc_count - start_acc == 1) data_in = 8'hFF;
      if (acc_count - start_acc >= 2) valid = 1'b0;
    end
    valid = 1'b0;
    check("b2b_done_count", dn, 2);
    check("b2b_done_gap", t1 - t0, FRAME + 1);
    repeat (3) tick();

    // pr while idle blocks acceptance.
    pr = 1'b1; valid = 1'b1; data_in = 8'h77;
    tick();
    pr = 1'b0; valid = 1'b0;
    tick();
    check("pr_idle_no_accept", s_busy, 1'b0);

    // Abort mid-frame.
    valid = 1'b1; data_in = 8'h00;
    tick();
    valid = 1'b0;
    repeat (14) tick();
    pr = 1'b1; valid = 1'b1; data_in = 8'h81;
    tick();
    pr = 1'b0;
    tick();
    check("abort_tx", s_tx, 1'b1);
    check("abort_busy", s_busy, 1'b0);
    check("abort_ready", s_ready, 1'b1);
    valid = 1'b0;
    tick();
    check("post_abort_accept_busy", s_busy, 1'b1);
    check("post_abort_accept_tx", s_tx, 1'b0);
    done_at = -1;
    for (int c = 1; c <= FRAME + 5 && done_at < 0; c++) begin
      tick();
      if (s_done) done_at = c;
    end
    check("post_abort_done_latency", done_at, FRAME);

    // Async reset mid-frame, between edges.
    valid = 1'b1; data_in = 8'h5A;
    tick();
    valid = 1'b0;
    repeat (12) tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    rst = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_k = 0;
    tick();
    send_frame(8'hC3, got, done_at);
    check("after_rst_bits", got, 10'b1_1100_0011_0);
    check("after_rst_done", done_at, FRAME);

    // Randomized traffic with aborts and data churn during frames.
    for (int t = 0; t < 1500; t++) begin
      pr = ($urandom_range(0, 49) == 0);
      valid = ($urandom_range(0, 3) != 0);
      data_in = 8'($urandom);
      tick();
    end
    pr = 1'b0; valid = 1'b0;
    repeat (FRAME + 2) tick();

    // Corner instance: WIDTH=1, BIT_CYCLES=1, STOP_BITS=2.
    for (int v = 0; v < 2; v++) begin
      check("c_ready_idle", c_ready, 1'b1);
      c_valid = 1'b1; c_data = 1'(v == 0);
      tick();
      c_valid = 1'b0; c_data = 1'(v != 0);
      cgot = '0; cdone = '0; cbusy = '0;
      for (int k = 0; k < 4; k++) begin
        tick();
        cgot[k] = s_ctx; cdone[k] = s_cdone; cbusy[k] = s_cbusy;
      end
      tick();
      check("c_tx_seq", cgot, (v == 0) ? 4'b1110 : 4'b1100);
      check("c_busy_seq", cbusy, 4'b1111);
      check("c_done_early", cdone, 4'b0000);
      check("c_done_4th", s_cdone, 1'b1);
      check("c_busy_end", s_cbusy, 1'b0);
      tick();
      check("c_done_pulse", s_cdone, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
